// File: rtl/display_arb_pkg.sv
// Shared owner encodings, display constants and the BCD-to-segment decoder
// used by the display owner arbiter and its scan engine.
package display_arb_pkg;

  localparam logic [1:0] OWN_BASE  = 2'd0;
  localparam logic [1:0] OWN_EVENT = 2'd1;
  localparam logic [1:0] OWN_PRIO  = 2'd2;

  typedef enum logic [1:0] {
    SHOW_BASE  = 2'd0,
    SHOW_EVENT = 2'd1,
    SHOW_PRIO  = 2'd2
  } owner_state_e;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam logic [6:0] SEG_OFF      = 7'h7F;
  localparam logic [7:0] AN_OFF       = 8'hFF;

  // Active-low gfedcba patterns; anything outside 0-9 renders as a dark digit.
  function automatic logic [6:0] seg7Decode(input logic [3:0] nibble);
    logic [6:0] segs;
    case (nibble)
      4'd0:    segs = 7'h40;
      4'd1:    segs = 7'h79;
      4'd2:    segs = 7'h24;
      4'd3:    segs = 7'h30;
      4'd4:    segs = 7'h19;
      4'd5:    segs = 7'h12;
      4'd6:    segs = 7'h02;
      4'd7:    segs = 7'h78;
      4'd8:    segs = 7'h00;
      4'd9:    segs = 7'h10;
      default: segs = SEG_OFF;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/display_owner_arbiter_scan.sv
// Digit scan engine: dwell counter, digit index, blank guard slot after an
// owner switch, and the registered seg/an outputs.
module seg7_scan
  import display_arb_pkg::*;
#(
  parameter int DWELL_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        resetN_i,
  input  logic [31:0] digits_i,
  input  logic [7:0]  blankMask_i,
  input  logic        restart_i,
  output logic [6:0]  seg_o,
  output logic [7:0]  an_o
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_CYCLES - 1);
  localparam logic          GUARD_MULTI = (DWELL_CYCLES > 1);
  // The restart cycle is itself the first guard cycle, so the count resumes at 1.
  localparam logic [DW-1:0] GUARD_START = GUARD_MULTI ? DW'(1) : '0;

  logic [DW-1:0] dwell_q, dwell_d;
  logic [2:0]    digitIdx_q, digitIdx_d;
  logic          guard_q, guard_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;

  logic          dwellLast;
  logic [3:0]    curNibble;
  logic [3:0]    shownNibble;

  assign dwellLast   = (dwell_q == DWELL_LAST);
  assign curNibble   = digits_i[{digitIdx_q, 2'b00} +: 4];
  assign shownNibble = blankMask_i[digitIdx_q] ? BLANK_NIBBLE : curNibble;

  always_comb begin
    dwell_d    = dwell_q;
    digitIdx_d = digitIdx_q;
    guard_d    = guard_q;
    seg_d      = SEG_OFF;
    an_d       = AN_OFF;
    if (restart_i) begin
      digitIdx_d = 3'd0;
      guard_d    = GUARD_MULTI;
      dwell_d    = GUARD_START;
    end else if (guard_q) begin
      if (dwellLast) begin
        guard_d = 1'b0;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end else begin
      an_d  = ~(8'b0000_0001 << digitIdx_q);
      seg_d = seg7Decode(shownNibble);
      if (dwellLast) begin
        dwell_d    = '0;
        digitIdx_d = digitIdx_q + 3'd1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetN_i) begin
      dwell_q    <= '0;
      digitIdx_q <= 3'd0;
      guard_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      dwell_q    <= dwell_d;
      digitIdx_q <= digitIdx_d;
      guard_q    <= guard_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: rtl/display_owner_arbiter.sv
// Chooses which client owns the shared 8-digit display (base, timed event
// overlay, or preempting priority view) and drives the scan engine.
module display_owner_arbiter
  import display_arb_pkg::*;
#(
  parameter int DWELL_CYCLES      = 65536,
  parameter int HOLD_CYCLES       = 200_000_000,
  parameter int BLINK_HALF_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] base_data,
  input  logic [31:0] ev_data,
  input  logic        ev_pulse,
  input  logic        prio_req,
  input  logic [31:0] prio_data,
  input  logic [7:0]  prio_blink,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic [1:0]  owner,
  output logic        ev_active
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;
  owner_state_e       state_q, state_d;

  logic               evActive;
  logic               restart;
  logic [31:0]        selDigits;
  logic [7:0]         blankMask;

  // A pulse always reloads, even on the cycle the count would have hit zero.
  always_comb begin
    holdCnt_d = holdCnt_q;
    if (ev_pulse) begin
      holdCnt_d = HOLD_LOAD;
    end else if (holdCnt_q != '0) begin
      holdCnt_d = holdCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      holdCnt_q <= '0;
    end else begin
      holdCnt_q <= holdCnt_d;
    end
  end

  assign evActive = (holdCnt_q != '0);

  always_comb begin
    blinkCnt_d   = blinkCnt_q + 1'b1;
    blinkPhase_d = blinkPhase_q;
    if (blinkCnt_q == BLINK_LAST) begin
      blinkCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SHOW_BASE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority preempts; an overlay that lapsed while preempted is not resumed.
  always_comb begin
    state_d = SHOW_BASE;
    if (prio_req) begin
      state_d = SHOW_PRIO;
    end else if (evActive) begin
      state_d = SHOW_EVENT;
    end
  end

  always_comb begin
    owner     = OWN_BASE;
    selDigits = base_data;
    blankMask = 8'h00;
    case (state_q)
      SHOW_EVENT: begin
        owner     = OWN_EVENT;
        selDigits = ev_data;
      end
      SHOW_PRIO: begin
        owner     = OWN_PRIO;
        selDigits = prio_data;
        blankMask = blinkPhase_q ? prio_blink : 8'h00;
      end
      default: begin
        owner     = OWN_BASE;
        selDigits = base_data;
      end
    endcase
  end

  assign restart = (state_d != state_q);

  seg7_scan #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_scan (
    .clk_i      (clk),
    .resetN_i   (reset_n),
    .digits_i   (selDigits),
    .blankMask_i(blankMask),
    .restart_i  (restart),
    .seg_o      (seg),
    .an_o       (an)
  );

  assign ev_active = evActive;

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Self-checking bench for display_owner_arbiter: a cycle-level reference model
// feeds a scoreboard, plus a decode vector table and targeted corner sequences.
module tb_display_owner_arbiter;

  localparam int DWELL = 4;
  localparam int HOLD  = 20;
  localparam int BLINK = 8;

  typedef struct {
    logic [6:0] seg;
    logic [7:0] an;
    logic [1:0] owner;
    logic       evActive;
  } expect_t;

  typedef struct {
    logic [3:0] nibble;
    logic [6:0] expSeg;
  } decode_vec_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] baseData;
  logic [31:0] evData;
  logic        evPulse;
  logic        prioReq;
  logic [31:0] prioData;
  logic [7:0]  prioBlink;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [1:0]  owner;
  logic        evActive;

  int vectorCount = 0;
  int miscompareCount = 0;
  int cycleNum = 0;
  expect_t sbQueue[$];
  decode_vec_t decodeVecs[16];

  int mHold = 0;
  int mOwner = 0;
  int mGuardLeft = 0;
  int mScanCycle = 0;
  int mBlinkCycle = 0;

  display_owner_arbiter #(
    .DWELL_CYCLES(DWELL),
    .HOLD_CYCLES(HOLD),
    .BLINK_HALF_CYCLES(BLINK)
  ) dut (
    .clk       (clk),
    .reset_n   (resetN),
    .base_data (baseData),
    .ev_data   (evData),
    .ev_pulse  (evPulse),
    .prio_req  (prioReq),
    .prio_data (prioData),
    .prio_blink(prioBlink),
    .seg       (seg),
    .an        (an),
    .owner     (owner),
    .ev_active (evActive)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] nibbleOf(input logic [31:0] data, input int digit);
    return data[digit*4 +: 4];
  endfunction

  // Reference model of one clock edge, using the inputs currently driven.
  task automatic modelEdge(output expect_t e);
    int nextOwner;
    int digit;
    logic [31:0] data;
    logic blinkOn;
    if (!resetN) begin
      mHold = 0; mOwner = 0; mGuardLeft = 0; mScanCycle = 0; mBlinkCycle = 0;
      e.seg = 7'h7F; e.an = 8'hFF; e.owner = 2'd0; e.evActive = 1'b0;
    end else begin
      nextOwner = prioReq ? 2 : ((mHold != 0) ? 1 : 0);
      blinkOn = ((mBlinkCycle / BLINK) % 2) == 1;
      if (nextOwner != mOwner) begin
        e.an = 8'hFF; e.seg = 7'h7F;
        mOwner = nextOwner; mGuardLeft = DWELL - 1; mScanCycle = 0;
      end else if (mGuardLeft > 0) begin
        e.an = 8'hFF; e.seg = 7'h7F;
        mGuardLeft--;
      end else begin
        digit = (mScanCycle / DWELL) % 8;
        data = (mOwner == 2) ? prioData : ((mOwner == 1) ? evData : baseData);
        e.an = 8'hFF ^ (8'h01 << digit);
        if (mOwner == 2 && blinkOn && prioBlink[digit])
          e.seg = 7'h7F;
        else
          e.seg = decodeVecs[nibbleOf(data, digit)].expSeg;
        mScanCycle++;
      end
      mHold = evPulse ? HOLD : ((mHold > 0) ? mHold - 1 : 0);
      mBlinkCycle++;
      e.owner = 2'(mOwner);
      e.evActive = (mHold != 0);
    end
  endtask

  task automatic applyStimulus();
    expect_t e;
    modelEdge(e);
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    expect_t e;
    vectorCount++;
    if (sbQueue.size() == 0) begin
      miscompareCount++;
      $display("[TB] FAIL scoreboard cycle %0d: got empty queue, expected an entry", cycleNum);
      return;
    end
    e = sbQueue.pop_front();
    if (seg !== e.seg || an !== e.an || owner !== e.owner || evActive !== e.evActive) begin
      miscompareCount++;
      $display("[TB] FAIL cycle %0d: got seg=%h an=%h owner=%0d ev=%b, expected seg=%h an=%h owner=%0d ev=%b",
               cycleNum, seg, an, owner, evActive, e.seg, e.an, e.owner, e.evActive);
    end
  endtask

  task automatic stepCycle();
    applyStimulus();
    @(posedge clk);
    #1;
    cycleNum++;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vectorCount++;
    if (act != exp) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int evCount;
    int ffCount;
    int evLow;
    int sawOwner1;
    int owner1AfterPrio;
    int sawPrio;
    int blankSeen;
    int shownSeen;
    int steadyBad;

    decodeVecs[0]  = '{4'h0, 7'h40};
    decodeVecs[1]  = '{4'h1, 7'h79};
    decodeVecs[2]  = '{4'h2, 7'h24};
    decodeVecs[3]  = '{4'h3, 7'h30};
    decodeVecs[4]  = '{4'h4, 7'h19};
    decodeVecs[5]  = '{4'h5, 7'h12};
    decodeVecs[6]  = '{4'h6, 7'h02};
    decodeVecs[7]  = '{4'h7, 7'h78};
    decodeVecs[8]  = '{4'h8, 7'h00};
    decodeVecs[9]  = '{4'h9, 7'h10};
    decodeVecs[10] = '{4'hA, 7'h7F};
    decodeVecs[11] = '{4'hB, 7'h7F};
    decodeVecs[12] = '{4'hC, 7'h7F};
    decodeVecs[13] = '{4'hD, 7'h7F};
    decodeVecs[14] = '{4'hE, 7'h7F};
    decodeVecs[15] = '{4'hF, 7'h7F};

    resetN = 1'b0; baseData = 32'h76543210; evData = 32'h23456789;
    evPulse = 1'b0; prioReq = 1'b0; prioData = 32'h00001234; prioBlink = 8'h00;

    $display("[TB] reset and base scan");
    runCycles(3);
    resetN = 1'b1;
    stepCycle();
    checkValue("first scan an", int'(an), 'hFE);
    checkValue("first scan seg", int'(seg), 'h40);
    runCycles(40);

    $display("[TB] decode table");
    for (int i = 0; i < 16; i++) begin
      baseData = {8{decodeVecs[i].nibble}};
      stepCycle();
      checkValue($sformatf("decode nibble %0h", decodeVecs[i].nibble), int'(seg), int'(decodeVecs[i].expSeg));
    end
    baseData = 32'h76543210;
    runCycles(10);

    $display("[TB] event overlay");
    evCount = 0; ffCount = 0;
    evPulse = 1'b1;
    stepCycle();
    evPulse = 1'b0;
    if (evActive) evCount++;
    if (an == 8'hFF) ffCount++;
    for (int i = 0; i < 30; i++) begin
      stepCycle();
      if (evActive) evCount++;
      if (an == 8'hFF) ffCount++;
    end
    checkValue("overlay ev_active cycles", evCount, 20);
    checkValue("overlay guard cycles", ffCount, 8);

    $display("[TB] retrigger");
    evCount = 0; ffCount = 0;
    for (int i = 0; i < 47; i++) begin
      evPulse = (i == 0 || i == 16);
      stepCycle();
      if (evActive) evCount++;
      if (an == 8'hFF) ffCount++;
    end
    evPulse = 1'b0;
    checkValue("retrigger ev_active cycles", evCount, 36);
    checkValue("retrigger guard cycles", ffCount, 8);

    $display("[TB] preemption");
    sawOwner1 = 0; owner1AfterPrio = 0; sawPrio = 0;
    evPulse = 1'b1;
    stepCycle();
    evPulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      if (owner == 2'd1) sawOwner1 = 1;
    end
    prioReq = 1'b1;
    stepCycle();
    checkValue("preempt owner", int'(owner), 2);
    checkValue("preempt guard an", int'(an), 'hFF);
    for (int i = 0; i < 40; i++) begin
      if (i == 29) prioReq = 1'b0;
      stepCycle();
      if (owner == 2'd2) sawPrio = 1;
      if (sawPrio == 1 && owner == 2'd1) owner1AfterPrio = 1;
    end
    checkValue("preempt saw owner 1 first", sawOwner1, 1);
    checkValue("preempt returned to owner 1", owner1AfterPrio, 0);
    checkValue("preempt final owner", int'(owner), 0);

    $display("[TB] blink");
    blankSeen = 0; shownSeen = 0; steadyBad = 0;
    prioBlink = 8'h0C; prioData = 32'h00001234;
    for (int run = 0; run < 2; run++) begin
      prioReq = 1'b1;
      for (int i = 0; i < 40; i++) begin
        stepCycle();
        if ((an == 8'hFB || an == 8'hF7) && seg == 7'h7F) blankSeen++;
        if ((an == 8'hFB && seg == 7'h24) || (an == 8'hF7 && seg == 7'h79)) shownSeen++;
        if ((an == 8'hFE && seg != 7'h19) || (an == 8'hFD && seg != 7'h30)) steadyBad++;
      end
      prioReq = 1'b0;
      runCycles(16);
    end
    checkValue("blink digits blanked", int'(blankSeen > 0), 1);
    checkValue("blink digits shown", int'(shownSeen > 0), 1);
    checkValue("blink steady digits", steadyBad, 0);
    prioBlink = 8'h00;

    $display("[TB] simultaneous pulse and priority");
    evPulse = 1'b1; prioReq = 1'b1;
    stepCycle();
    evPulse = 1'b0;
    checkValue("simultaneous owner", int'(owner), 2);
    checkValue("simultaneous ev_active", int'(evActive), 1);
    checkValue("simultaneous an", int'(an), 'hFF);
    runCycles(5);
    prioReq = 1'b0;
    stepCycle();
    checkValue("after priority owner", int'(owner), 1);
    runCycles(30);

    $display("[TB] reload at expiry");
    evLow = 0;
    for (int i = 0; i < 51; i++) begin
      evPulse = (i == 0 || i == 20);
      stepCycle();
      if (i <= 30 && !evActive) evLow++;
    end
    evPulse = 1'b0;
    checkValue("reload gap cycles", evLow, 0);

    $display("[TB] reset during guard");
    evPulse = 1'b1;
    stepCycle();
    evPulse = 1'b0;
    runCycles(2);
    resetN = 1'b0;
    stepCycle();
    checkValue("mid-guard reset an", int'(an), 'hFF);
    checkValue("mid-guard reset seg", int'(seg), 'h7F);
    checkValue("mid-guard reset owner", int'(owner), 0);
    checkValue("mid-guard reset ev_active", int'(evActive), 0);
    resetN = 1'b1;
    stepCycle();
    checkValue("post-reset an", int'(an), 'hFE);
    checkValue("post-reset seg", int'(seg), 'h40);
    runCycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/display_owner_arbiter.md
# display_owner_arbiter

Sequencer for the shared 8-digit active-low 7-segment display on the Nexys A7 watch designs. It arbitrates the single scan/decode datapath between three clients: a base view, a timed event overlay, and a preempting priority view. The clients are the stopwatch/timer, the lap snapshot and set mode. It owns digit scanning, blink gating and a blank guard slot on every owner switch, so clients only supply BCD nibbles.

## Interface
Parameters:
- `DWELL_CYCLES`, 65536: cycles each digit is driven per scan slot.
- `HOLD_CYCLES`, 200_000_000: event overlay duration after `ev_pulse` (2 s at 100 MHz).
- `BLINK_HALF_CYCLES`, 25_000_000: half-period of the blink phase.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `base_data` in 32: owner-0 digits; nibble i drives digit i; 0-9 are shown, any other value is blank.
- `ev_data` in 32: owner-1 digits, same encoding.
- `ev_pulse` in 1: single-cycle strobe that starts or retriggers the overlay.
- `prio_req` in 1: level request for owner 2; preempts everything.
- `prio_data` in 32: owner-2 digits.
- `prio_blink` in 8: per-digit blink enable, owner 2 only.
- `seg` out 7: active-low segments, gfedcba.
- `an` out 8: active-low anodes.
- `owner` out 2: current owner; 0 = base, 1 = event, 2 = priority.
- `ev_active` out 1: overlay hold in progress.

## Operation
- Hold counter `hold_cnt` has width clog2(HOLD_CYCLES+1).
  - `ev_pulse` loads HOLD_CYCLES; this includes retrigger while active.
  - Otherwise it decrements when nonzero.
  - `ev_active` = (`hold_cnt` != 0).
  - The counter runs whether or not owner 2 is showing.
- Owner FSM states: SHOW_BASE, SHOW_EVENT, SHOW_PRIO. The next owner is evaluated every cycle:
  - If `prio_req` is high: SHOW_PRIO.
  - Else if `ev_active`: SHOW_EVENT.
  - Else: SHOW_BASE.
  - When the overlay expires while preempted, release of `prio_req` goes directly to SHOW_BASE.
- Owner change (next ≠ current) triggers the guard:
  - Load a guard dwell: `an` = 8'hFF for DWELL_CYCLES.
  - Then restart the scan at digit 0.
  - A further owner change during the guard restarts the guard.
- Scan:
  - The dwell counter counts 0..DWELL_CYCLES-1.
  - On terminal count, the digit index increments and wraps 7→0.
  - Digit i drives `an` with bit i low, all others high.
- Blink:
  - `blink_phase` toggles every BLINK_HALF_CYCLES and resets to 0.
  - When owner = 2, `prio_blink[i]` = 1 and `blink_phase` = 1, digit i is blanked.
  - Its anode stays low and `seg` = 7'h7F.
- Decode (0-9): 40,79,24,30,19,12,02,78,00,10 hex. Nibbles 10-15 give 7'h7F.
- Client data is not latched. The selected owner's live nibble is used each cycle.

## Timing
- Reset values while `reset_n` is low at an edge:
  - `seg` = 7'h7F, `an` = 8'hFF, `owner` = 0, `ev_active` = 0.
  - `hold_cnt` = 0, scan index 0, dwell 0, `blink_phase` 0, no guard.
- First edge with `reset_n` high: `an` = 8'hFE, `seg` shows base nibble 0.
- `seg`, `an` and `owner` are registered, with one cycle of latency from inputs.
- `ev_pulse` sampled at edge k: `ev_active` = 1 after edge k, and stays high for exactly HOLD_CYCLES cycles.
  - `owner` = 1 after edge k+1 (if `prio_req` is low), and the guard starts at that edge.
- `prio_req` sampled high at edge k: `owner` = 2 and `an` = 8'hFF after edge k.
- Simultaneous `ev_pulse` and `prio_req`: owner 2 wins, and the hold still loads.
- `ev_pulse` on the same cycle the counter would reach 0: the reload wins, so there is no gap.
- Reset asserted mid-guard or mid-hold: everything returns to reset values on that edge.

## Structure
- Package `display_arb_pkg`:
  - Owner encodings OWN_BASE/OWN_EVENT/OWN_PRIO.
  - BLANK_NIBBLE 4'hF, SEG_OFF 7'h7F, AN_OFF 8'hFF.
  - Decode table function.
- Sub-module `seg7_scan`:
  - Owns the dwell counter, digit index, guard sequencing and output registers.
  - Takes a 32-bit digit vector, an 8-bit blank mask and a restart strobe.
- Top level holds the hold counter, blink phase and owner FSM, about 250 lines total.
- Bench parameters: DWELL_CYCLES=4, HOLD_CYCLES=20, BLINK_HALF_CYCLES=8.

## Test plan
- Reset: `reset_n` low 3 cycles, `base_data` = 32'h76543210 → `an` = FF and `seg` = 7F during reset; then `an` FE/`seg` 40 for 4 cycles, FD/79 for 4 cycles, through 7F/78, then wrap to FE.
- Event overlay: `ev_pulse` at cycle 10 → `ev_active` high for 20 cycles, `owner` = 1, `an` = FF for 4 cycles, then `ev_data` digit 0 is shown; `owner` returns to 0 after expiry, with a second guard.
- Retrigger: second `ev_pulse` at 15 cycles into the hold → `ev_active` stays continuously high for another 20 cycles, with no owner change and no extra guard.
- Preemption: `prio_req` high during the hold, dropped after the hold expired → `owner` 1→2→0, never returning to 1.
- Blink: owner 2, `prio_blink` = 8'h0C, `prio_data` = 32'h00001234 → digits 2 and 3 alternate between `seg` 7F and decoded every 8 cycles, with their anodes still driven low; digits 0 and 1 steady.
- Blank nibbles and reset mid-guard: `base_data` nibbles A-F → `seg` = 7F; dropping `reset_n` during a guard → reset values on the next edge, then a clean scan from digit 0.
